mem_access_unit: RTL

Load/store access unit for the MEM stage, between the EX/MEM pipeline register and the byte-addressed, big-endian, word-wide data memory. Converts byte, halfword and word loads and stores into word-aligned memory transactions. Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended. Misaligned and reserved-size accesses are flagged and dropped. The pipeline is stalled while a two-cycle access is in progress.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit for a big-endian word-wide data memory
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] dm_address,
  output logic [31:0] dm_writeData,
  output logic        dm_memWrite,
  output logic        dm_memRead,
  input  logic [31:0] dm_readData,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        access_fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;

  logic        req;
  logic        is_store;
  logic        fault;
  logic [1:0]  offset;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] extended;
  logic [31:0] merged;

  // The request is held stable while stalled, so the same inputs describe
  // the access in both of its cycles.
  assign offset     = addr[1:0];
  assign req        = mem_read | mem_write;
  assign is_store   = mem_write;
  assign dm_address = {addr[31:2], 2'b00};

  // Reserved size or an address not aligned to the access size.
  assign fault = (size == 2'b11) ||
                 ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Pick the addressed byte / halfword lane out of the read word (big-endian).
  always_comb begin
    byte_lane = dm_readData[31:24];
    case (offset)
      2'd0:    byte_lane = dm_readData[31:24];
      2'd1:    byte_lane = dm_readData[23:16];
      2'd2:    byte_lane = dm_readData[15:8];
      default: byte_lane = dm_readData[7:0];
    endcase
    half_lane = offset[1] ? dm_readData[15:0] : dm_readData[31:16];
  end

  // Sign- or zero-extend the selected lane; words pass through.
  always_comb begin
    extended = dm_readData;
    case (size)
      SZ_BYTE: extended = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: extended = {{16{~load_unsigned & half_lane[15]}}, half_lane};
      default: extended = dm_readData;
    endcase
  end

  // Overlay the store lane onto the word fetched in the read cycle.
  always_comb begin
    merged = dm_readData;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd0:    merged[31:24] = store_data[7:0];
        2'd1:    merged[23:16] = store_data[7:0];
        2'd2:    merged[15:8]  = store_data[7:0];
        default: merged[7:0]   = store_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) begin
        merged[15:0] = store_data[15:0];
      end else begin
        merged[31:16] = store_data[15:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and combinational outputs; reset overrides everything.
  always_comb begin
    state_d      = state_q;
    dm_writeData = 32'h0;
    dm_memWrite  = 1'b0;
    dm_memRead   = 1'b0;
    load_data    = 32'h0;
    load_valid   = 1'b0;
    stall        = 1'b0;
    access_fault = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (fault) begin
            access_fault = 1'b1;
          end else if (is_store && (size == SZ_WORD)) begin
            dm_memWrite  = 1'b1;
            dm_writeData = store_data;
          end else if (is_store) begin
            dm_memRead = 1'b1;
            stall      = 1'b1;
            state_d    = RMW_WRITE;
          end else begin
            dm_memRead = 1'b1;
            stall      = 1'b1;
            state_d    = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        load_valid = 1'b1;
        load_data  = extended;
        state_d    = IDLE;
      end
      RMW_WRITE: begin
        dm_memWrite  = 1'b1;
        dm_writeData = merged;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      state_d      = IDLE;
      dm_writeData = 32'h0;
      dm_memWrite  = 1'b0;
      dm_memRead   = 1'b0;
      load_data    = 32'h0;
      load_valid   = 1'b0;
      stall        = 1'b0;
      access_fault = 1'b0;
    end
  end

endmodule
